// File: rtl/conv_encoder_engine_pkg.sv
// Shared types and helpers for the framed convolutional encoder.
package conv_enc_pkg;

  typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

  localparam logic [7:0] G_INIT_DEF = 8'b1111_1101;

  // Ceiling log2 that never returns 0, so a 1-entry index still gets a bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/conv_encoder_engine_if.sv
// Config, input and output handshakes of the encoder engine.
interface conv_encoder_engine_if #(
  parameter int N = 2,
  parameter int K = 4
);
  localparam int AW = conv_enc_pkg::clog2(N);

  logic          cfg_load;
  logic [AW-1:0] cfg_addr;
  logic [0:K-1]  cfg_data;
  logic          cfg_ack;
  logic          in_valid;
  logic          in_ready;
  logic          in_bit;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [0:N-1]  out_sym;
  logic          out_last;
  logic          busy;

  modport master (
    output cfg_load, cfg_addr, cfg_data, in_valid, in_bit, in_last, out_ready,
    input  cfg_ack, in_ready, out_valid, out_sym, out_last, busy
  );

  modport slave (
    input  cfg_load, cfg_addr, cfg_data, in_valid, in_bit, in_last, out_ready,
    output cfg_ack, in_ready, out_valid, out_sym, out_last, busy
  );
endinterface

// File: rtl/conv_encoder_engine_poly_bank.sv
// N x K generator polynomial registers plus per-polynomial parity over the window.
module conv_enc_poly_bank #(
  parameter int             N      = 2,
  parameter int             K      = 4,
  parameter int             AW     = 1,
  parameter logic [N*K-1:0] G_INIT = '1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [0:K-1]  i_wdata,
  input  logic [0:K-1]  i_win,
  output logic [0:N-1]  o_par
);

  logic [0:N-1][0:K-1] r_g;

  always_ff @(posedge clk) begin
    if (!reset) begin
      // g[0] sits in the MSBs of the packed reset vector
      for (int i = 0; i < N; i++)
        r_g[i] <= G_INIT[(N-1-i)*K +: K];
    end else if (i_we) begin
      r_g[i_waddr] <= i_wdata;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_par
    assign o_par[i] = ^(r_g[i] & i_win);
  end

endmodule

// File: rtl/conv_encoder_engine.sv
// Framed rate-1/N convolutional encoder: one bit in, one N-bit symbol out, optional zero tail.
module conv_encoder_engine
  import conv_enc_pkg::*;
#(
  parameter int             N       = 2,
  parameter int             K       = 4,
  parameter int             TAIL_EN = 1,
  parameter logic [N*K-1:0] G_INIT  = G_INIT_DEF
) (
  input logic                   clk,
  input logic                   reset,
  conv_encoder_engine_if.slave  bus
);

  localparam int AW = clog2(N);
  localparam int TW = clog2(K);

  state_t        r_state;
  logic [0:K-2]  r_sr;
  logic [TW-1:0] r_tail_cnt;
  logic          r_out_valid;
  logic [0:N-1]  r_out_sym;
  logic          r_out_last;
  logic          r_cfg_ack;

  logic          w_slot_free;
  logic          w_cfg_ok;
  logic          w_in_ready;
  logic          w_acc;
  logic          w_cur;
  logic [0:K-1]  w_win;
  logic [0:K-2]  w_sr_shift;
  logic [0:N-1]  w_par;

  assign w_slot_free = !r_out_valid || bus.out_ready;
  assign w_cfg_ok    = bus.cfg_load && (r_state == IDLE) && !r_out_valid &&
                       (int'(bus.cfg_addr) < N);
  // A config write that lands in IDLE takes the cycle; the input bit waits.
  assign w_in_ready  = reset && (r_state != TAIL) && w_slot_free && !w_cfg_ok;
  assign w_acc       = bus.in_valid && w_in_ready;
  assign w_cur       = (r_state == TAIL) ? 1'b0 : bus.in_bit;
  assign w_win       = {w_cur, r_sr};
  assign w_sr_shift  = {w_cur, r_sr[0:K-3]};

  conv_enc_poly_bank #(.N(N), .K(K), .AW(AW), .G_INIT(G_INIT)) u_bank (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_cfg_ok),
    .i_waddr (bus.cfg_addr),
    .i_wdata (bus.cfg_data),
    .i_win   (w_win),
    .o_par   (w_par)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_sr        <= '0;
      r_tail_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_sym   <= '0;
      r_out_last  <= 1'b0;
      r_cfg_ack   <= 1'b0;
    end else begin
      r_cfg_ack <= w_cfg_ok;
      if (w_slot_free) r_out_valid <= 1'b0;
      case (r_state)
        IDLE, RUN: begin
          if (w_acc) begin
            r_out_valid <= 1'b1;
            r_out_sym   <= w_par;
            if (bus.in_last && TAIL_EN == 0) begin
              r_sr       <= '0;
              r_out_last <= 1'b1;
              r_state    <= IDLE;
            end else begin
              r_sr       <= w_sr_shift;
              r_out_last <= 1'b0;
              r_state    <= bus.in_last ? TAIL : RUN;
            end
          end
        end
        TAIL: begin
          if (w_slot_free) begin
            r_out_valid <= 1'b1;
            r_out_sym   <= w_par;
            r_sr        <= w_sr_shift;
            // K-1 zeros flush the register, so sr is clear on return to IDLE
            if (r_tail_cnt == TW'(K-2)) begin
              r_out_last <= 1'b1;
              r_tail_cnt <= '0;
              r_state    <= IDLE;
            end else begin
              r_out_last <= 1'b0;
              r_tail_cnt <= r_tail_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sym   = r_out_sym;
  assign bus.out_last  = r_out_last;
  assign bus.cfg_ack   = r_cfg_ack;
  assign bus.busy      = (r_state != IDLE) || r_out_valid;

endmodule

// File: tb/tb_conv_encoder_engine.sv
// Directed bench: tailed N=2 engine (A) and untailed N=3 engine (B) on one clock.
module tb_conv_encoder_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  conv_encoder_engine_if #(.N(2), .K(4)) a_if ();
  conv_encoder_engine_if #(.N(3), .K(4)) b_if ();

  conv_encoder_engine #(.N(2), .K(4), .TAIL_EN(1), .G_INIT(8'b1111_1101)) dut_a (
    .clk(clk), .reset(rst_a), .bus(a_if.slave));
  conv_encoder_engine #(.N(3), .K(4), .TAIL_EN(0), .G_INIT(12'b1111_1101_1011)) dut_b (
    .clk(clk), .reset(rst_b), .bus(b_if.slave));

  logic [1:0] qa_sym[$];
  bit         qa_last[$];
  int         qa_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Records every symbol handed over on engine A.
  always @(negedge clk) begin
    if (a_if.out_valid === 1'b1 && a_if.out_ready === 1'b1) begin
      qa_sym.push_back(a_if.out_sym);
      qa_last.push_back(a_if.out_last);
      qa_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_a(input logic b, input logic l);
    bit acc = 0;
    a_if.in_valid = 1'b1; a_if.in_bit = b; a_if.in_last = l;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk); acc = (a_if.in_ready === 1'b1);
      @(posedge clk); #1;
    end
    a_if.in_valid = 1'b0; a_if.in_last = 1'b0;
    checks++;
    if (!acc) begin failures++; $display("FAIL send_a accept timeout got=0 exp=1"); end
  endtask

  task automatic send_b(input logic b, input logic l);
    bit acc = 0;
    b_if.in_valid = 1'b1; b_if.in_bit = b; b_if.in_last = l;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk); acc = (b_if.in_ready === 1'b1);
      @(posedge clk); #1;
    end
    b_if.in_valid = 1'b0; b_if.in_last = 1'b0;
    checks++;
    if (!acc) begin failures++; $display("FAIL send_b accept timeout got=0 exp=1"); end
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    a_if.in_valid = 1'b1;
    step(); step(); step();
    checks++; if (a_if.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", a_if.in_ready); end
    checks++; if (a_if.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", a_if.out_valid); end
    checks++; if (a_if.out_sym !== 2'b00) begin failures++; $display("FAIL reset_out_sym got=%b exp=00", a_if.out_sym); end
    checks++; if (a_if.busy !== 1'b0 || a_if.cfg_ack !== 1'b0 || a_if.out_last !== 1'b0) begin
      failures++; $display("FAIL reset_flags busy=%b ack=%b last=%b exp=000", a_if.busy, a_if.cfg_ack, a_if.out_last); end
    a_if.in_valid = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    step();
    checks++; if (a_if.in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready got=%b exp=1", a_if.in_ready); end
  endtask

  task automatic test_basic();
    logic [1:0] exp[7] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11};
    logic       bits[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_a(bits[i], i == 3);
      checks++;
      if (a_if.out_valid !== 1'b1 || a_if.out_sym !== exp[i] || a_if.out_last !== 1'b0) begin
        failures++; $display("FAIL basic_sym%0d got v=%b s=%b l=%b exp v=1 s=%b l=0",
                             i, a_if.out_valid, a_if.out_sym, a_if.out_last, exp[i]); end
    end
    for (int t = 0; t < 3; t++) begin
      step();
      checks++;
      if (a_if.out_valid !== 1'b1 || a_if.out_sym !== exp[4+t] || a_if.out_last !== (t == 2)) begin
        failures++; $display("FAIL basic_tail%0d got v=%b s=%b l=%b exp v=1 s=%b l=%b",
                             t, a_if.out_valid, a_if.out_sym, a_if.out_last, exp[4+t], (t == 2)); end
    end
    step();
    checks++;
    if (a_if.out_valid !== 1'b0 || a_if.busy !== 1'b0) begin
      failures++; $display("FAIL basic_idle got v=%b busy=%b exp 0 0", a_if.out_valid, a_if.busy); end
  endtask

  task automatic test_stall();
    logic [1:0] exp[7] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11};
    logic       bits[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic       pat[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    qa_sym.delete(); qa_last.delete(); qa_cyc.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) send_a(bits[i], i == 3);
      end
      begin
        bit         prev_stall = 0;
        logic [1:0] held = '0;
        for (int c = 0; c < 40; c++) begin
          a_if.out_ready = pat[c % 4];
          @(negedge clk);
          if (prev_stall) begin
            checks++;
            if (a_if.out_valid !== 1'b1 || a_if.out_sym !== held) begin
              failures++; $display("FAIL stall_hold c=%0d got v=%b s=%b exp v=1 s=%b",
                                   c, a_if.out_valid, a_if.out_sym, held); end
          end
          if (a_if.out_valid === 1'b1 && a_if.out_ready === 1'b0) begin
            checks++;
            if (a_if.in_ready !== 1'b0) begin
              failures++; $display("FAIL stall_in_ready c=%0d got=%b exp=0", c, a_if.in_ready); end
          end
          prev_stall = (a_if.out_valid === 1'b1 && a_if.out_ready === 1'b0);
          held = a_if.out_sym;
          @(posedge clk); #1;
        end
      end
    join
    a_if.out_ready = 1'b1;
    repeat (5) step();
    checks++;
    if (qa_sym.size() != 7) begin failures++; $display("FAIL stall_count got=%0d exp=7", qa_sym.size()); end
    else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (qa_sym[i] !== exp[i] || qa_last[i] !== (i == 6)) begin
          failures++; $display("FAIL stall_sym%0d got s=%b l=%b exp s=%b l=%b",
                               i, qa_sym[i], qa_last[i], exp[i], (i == 6)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp[4] = '{2'b11, 2'b11, 2'b10, 2'b11};
    qa_sym.delete(); qa_last.delete(); qa_cyc.delete();
    a_if.out_ready = 1'b1;
    send_a(1'b1, 1'b1);
    send_a(1'b1, 1'b1);
    repeat (6) step();
    checks++;
    if (qa_sym.size() != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", qa_sym.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (qa_sym[i] !== exp[i % 4] || qa_last[i] !== (i % 4 == 3) || qa_cyc[i] != qa_cyc[0] + i) begin
          failures++; $display("FAIL b2b_sym%0d got s=%b l=%b dc=%0d exp s=%b l=%b dc=%0d",
                               i, qa_sym[i], qa_last[i], qa_cyc[i] - qa_cyc[0], exp[i % 4], (i % 4 == 3), i); end
      end
    end
  endtask

  task automatic test_cfg();
    logic [1:0] exp[4] = '{2'b11, 2'b10, 2'b11, 2'b11};
    a_if.out_ready = 1'b1;
    a_if.cfg_load = 1'b1; a_if.cfg_addr = 1'b1; a_if.cfg_data = 4'b1011;
    a_if.in_valid = 1'b1; a_if.in_bit = 1'b1; a_if.in_last = 1'b1;
    @(negedge clk);
    checks++; if (a_if.in_ready !== 1'b0) begin failures++; $display("FAIL cfg_wins_in_ready got=%b exp=0", a_if.in_ready); end
    step();
    a_if.cfg_load = 1'b0; a_if.in_valid = 1'b0; a_if.in_last = 1'b0;
    checks++; if (a_if.cfg_ack !== 1'b1) begin failures++; $display("FAIL cfg_ack got=%b exp=1", a_if.cfg_ack); end
    checks++; if (a_if.out_valid !== 1'b0) begin failures++; $display("FAIL cfg_bit_blocked got=%b exp=0", a_if.out_valid); end
    step();
    checks++; if (a_if.cfg_ack !== 1'b0) begin failures++; $display("FAIL cfg_ack_pulse got=%b exp=0", a_if.cfg_ack); end
    qa_sym.delete(); qa_last.delete(); qa_cyc.delete();
    send_a(1'b1, 1'b1);
    repeat (5) step();
    checks++;
    if (qa_sym.size() != 4) begin failures++; $display("FAIL cfg_count got=%0d exp=4", qa_sym.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (qa_sym[i] !== exp[i] || qa_last[i] !== (i == 3)) begin
          failures++; $display("FAIL cfg_sym%0d got s=%b l=%b exp s=%b l=%b", i, qa_sym[i], qa_last[i], exp[i], (i == 3)); end
      end
    end
    // write attempted mid-frame must be dropped
    send_a(1'b1, 1'b0);
    a_if.cfg_load = 1'b1; a_if.cfg_addr = 1'b1; a_if.cfg_data = 4'b1101;
    step();
    a_if.cfg_load = 1'b0;
    checks++; if (a_if.cfg_ack !== 1'b0) begin failures++; $display("FAIL cfg_run_ack got=%b exp=0", a_if.cfg_ack); end
    send_a(1'b0, 1'b1);
    checks++; if (a_if.out_sym !== 2'b10) begin failures++; $display("FAIL cfg_run_unchanged got=%b exp=10", a_if.out_sym); end
    repeat (5) step();
  endtask

  task automatic test_reset_tail();
    logic [1:0] exp[4] = '{2'b11, 2'b11, 2'b10, 2'b11};
    a_if.out_ready = 1'b1;
    send_a(1'b1, 1'b1);
    step();
    rst_a = 1'b0;
    step();
    checks++;
    if (a_if.out_valid !== 1'b0 || a_if.busy !== 1'b0 || a_if.in_ready !== 1'b0) begin
      failures++; $display("FAIL rst_tail got v=%b busy=%b rdy=%b exp 0 0 0", a_if.out_valid, a_if.busy, a_if.in_ready); end
    rst_a = 1'b1;
    step();
    qa_sym.delete(); qa_last.delete(); qa_cyc.delete();
    send_a(1'b1, 1'b1);
    repeat (5) step();
    checks++;
    if (qa_sym.size() != 4) begin failures++; $display("FAIL rst_tail_count got=%0d exp=4", qa_sym.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (qa_sym[i] !== exp[i] || qa_last[i] !== (i == 3)) begin
          failures++; $display("FAIL rst_tail_sym%0d got s=%b l=%b exp s=%b l=%b", i, qa_sym[i], qa_last[i], exp[i], (i == 3)); end
      end
    end
  endtask

  task automatic test_notail();
    b_if.out_ready = 1'b1;
    send_b(1'b1, 1'b0);
    checks++; if (b_if.out_sym !== 3'b111 || b_if.out_last !== 1'b0) begin
      failures++; $display("FAIL notail_sym0 got s=%b l=%b exp s=111 l=0", b_if.out_sym, b_if.out_last); end
    send_b(1'b1, 1'b1);
    checks++; if (b_if.out_sym !== 3'b001 || b_if.out_last !== 1'b1) begin
      failures++; $display("FAIL notail_sym1 got s=%b l=%b exp s=001 l=1", b_if.out_sym, b_if.out_last); end
    step();
    checks++; if (b_if.out_valid !== 1'b0 || b_if.busy !== 1'b0) begin
      failures++; $display("FAIL notail_idle got v=%b busy=%b exp 0 0", b_if.out_valid, b_if.busy); end
    send_b(1'b1, 1'b1);
    checks++; if (b_if.out_sym !== 3'b111 || b_if.out_last !== 1'b1) begin
      failures++; $display("FAIL notail_sr_clear got s=%b l=%b exp s=111 l=1", b_if.out_sym, b_if.out_last); end
    step();
  endtask

  task automatic test_bad_addr();
    b_if.cfg_load = 1'b1; b_if.cfg_addr = 2'd3; b_if.cfg_data = 4'b0000;
    step();
    b_if.cfg_load = 1'b0;
    checks++; if (b_if.cfg_ack !== 1'b0) begin failures++; $display("FAIL bad_addr_ack got=%b exp=0", b_if.cfg_ack); end
    send_b(1'b1, 1'b1);
    checks++; if (b_if.out_sym !== 3'b111) begin failures++; $display("FAIL bad_addr_sym got=%b exp=111", b_if.out_sym); end
    step();
    b_if.cfg_load = 1'b1; b_if.cfg_addr = 2'd2; b_if.cfg_data = 4'b0100;
    step();
    b_if.cfg_load = 1'b0;
    checks++; if (b_if.cfg_ack !== 1'b1) begin failures++; $display("FAIL good_addr_ack got=%b exp=1", b_if.cfg_ack); end
    step();
    send_b(1'b1, 1'b1);
    checks++; if (b_if.out_sym !== 3'b110) begin failures++; $display("FAIL good_addr_sym got=%b exp=110", b_if.out_sym); end
    step();
  endtask

  initial begin
    a_if.cfg_load = 1'b0; a_if.cfg_addr = '0; a_if.cfg_data = '0;
    a_if.in_valid = 1'b0; a_if.in_bit = 1'b0; a_if.in_last = 1'b0; a_if.out_ready = 1'b1;
    b_if.cfg_load = 1'b0; b_if.cfg_addr = '0; b_if.cfg_data = '0;
    b_if.in_valid = 1'b0; b_if.in_bit = 1'b0; b_if.in_last = 1'b0; b_if.out_ready = 1'b1;
    rst_a = 1'b0; rst_b = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_cfg();
    test_reset_tail();
    test_notail();
    test_bad_addr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
